// File: rtl/fp_mant_addsub_pipe_if.sv
// Operand/result handshake bundle for the mantissa add/sub pipeline.
// FP_MANT_ADDSUB_OP_EN adds the op_sub operand bit.
interface fp_mant_addsub_pipe_if #(
    parameter int MW = 11
) ();
    localparam int LZW = $clog2(MW + 1);

    logic           in_valid;
    logic           in_ready;
    logic           sign_a;
    logic           sign_b;
    logic [MW-1:0]  m_a;
    logic [MW-1:0]  m_b;
`ifdef FP_MANT_ADDSUB_OP_EN
    logic           op_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic           res_sign;
    logic [MW-1:0]  res_mant;
    logic           res_carry;
    logic [LZW-1:0] res_lzc;
    logic           res_lost;
    logic           res_zero;

    modport master (
`ifdef FP_MANT_ADDSUB_OP_EN
        output op_sub,
`endif
        output in_valid, sign_a, sign_b, m_a, m_b, out_ready,
        input  in_ready, out_valid, res_sign, res_mant,
        input  res_carry, res_lzc, res_lost, res_zero
    );

    modport slave (
`ifdef FP_MANT_ADDSUB_OP_EN
        input  op_sub,
`endif
        input  in_valid, sign_a, sign_b, m_a, m_b, out_ready,
        output in_ready, out_valid, res_sign, res_mant,
        output res_carry, res_lzc, res_lost, res_zero
    );
endinterface

// File: rtl/fp_mant_addsub_pipe.sv
// Two-stage sign-magnitude mantissa add/sub with post-add normalisation.
// Optional FP_MANT_ADDSUB_OP_EN: op_sub inverts the effective sign of B.
module fp_mant_addsub_pipe #(
    parameter int MW = 11
) (
    input logic                  clk,
    input logic                  rst,
    fp_mant_addsub_pipe_if.slave bus
);
    localparam int LZW = $clog2(MW + 1);

    logic           v1_q;
    logic           v2_q;
    logic [MW:0]    s1_sum_q;
    logic           s1_sign_q;
    logic           res_sign_q;
    logic [MW-1:0]  res_mant_q;
    logic           res_carry_q;
    logic [LZW-1:0] res_lzc_q;
    logic           res_lost_q;
    logic           res_zero_q;

    logic           ld1;
    logic           ld2;
    logic           sb_eff;
    logic [MW:0]    sum_d;
    logic           sign_d;
    logic [MW-1:0]  mant_d;
    logic           carry_d;
    logic [LZW-1:0] lzc_d;
    logic           lost_d;
    logic           zero_d;
    logic           found;

`ifdef FP_MANT_ADDSUB_OP_EN
    assign sb_eff = bus.sign_b ^ bus.op_sub;
`else
    assign sb_eff = bus.sign_b;
`endif

    assign bus.in_ready  = !v1_q || !v2_q || bus.out_ready;
    assign ld1           = bus.in_valid && bus.in_ready;
    assign ld2           = v1_q && (!v2_q || bus.out_ready);

    assign bus.out_valid = v2_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.res_mant  = res_mant_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_lzc   = res_lzc_q;
    assign bus.res_lost  = res_lost_q;
    assign bus.res_zero  = res_zero_q;

    // Stage 1: magnitude add or larger-minus-smaller, sign follows the winner.
    always_comb begin
        sum_d  = '0;
        sign_d = 1'b0;
        if (bus.sign_a == sb_eff) begin
            sum_d  = {1'b0, bus.m_a} + {1'b0, bus.m_b};
            sign_d = bus.sign_a;
        end else if (bus.m_a > bus.m_b) begin
            sum_d  = {1'b0, bus.m_a - bus.m_b};
            sign_d = bus.sign_a;
        end else if (bus.m_b > bus.m_a) begin
            sum_d  = {1'b0, bus.m_b - bus.m_a};
            sign_d = sb_eff;
        end
    end

    // Stage 2: carry right-shift, or leading-zero count and left-shift.
    always_comb begin
        found   = 1'b0;
        lzc_d   = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && s1_sum_q[i]) begin
                found = 1'b1;
                lzc_d = LZW'(MW - 1 - i);
            end
        end
        carry_d = s1_sum_q[MW];
        zero_d  = (s1_sum_q == '0);
        lost_d  = 1'b0;
        mant_d  = '0;
        if (carry_d) begin
            mant_d = s1_sum_q[MW:1];
            lost_d = s1_sum_q[0];
            lzc_d  = '0;
        end else if (!zero_d) begin
            mant_d = s1_sum_q[MW-1:0] << lzc_d;
        end
    end

    // Pipeline registers and stage-valid flags; reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_sum_q    <= '0;
            s1_sign_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            res_mant_q  <= '0;
            res_carry_q <= 1'b0;
            res_lzc_q   <= '0;
            res_lost_q  <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q      <= 1'b1;
                s1_sum_q  <= sum_d;
                s1_sign_q <= sign_d;
            end else if (ld2) begin
                v1_q <= 1'b0;
            end
            if (ld2) begin
                v2_q        <= 1'b1;
                res_sign_q  <= s1_sign_q;
                res_mant_q  <= mant_d;
                res_carry_q <= carry_d;
                res_lzc_q   <= lzc_d;
                res_lost_q  <= lost_d;
                res_zero_q  <= zero_d;
            end else if (bus.out_ready) begin
                v2_q <= 1'b0;
            end
        end
    end
endmodule
